// File: rtl/matrix_op_defs_pkg.sv
// Shared definitions for the matrix operation units: storage geometry,
// metadata word encoding and the result-writer state type.
package matrix_op_defs_pkg;

  localparam int MATRIX_DATA_WIDTH     = 32;
  localparam int MATRIX_ADDR_WIDTH     = 12;
  localparam int MATRIX_BLOCK_SIZE     = 256;
  localparam int MATRIX_METADATA_WORDS = 4;
  localparam int MATRIX_DATA_CAPACITY  = MATRIX_BLOCK_SIZE - MATRIX_METADATA_WORDS;

  // Slot 7 is scratch space for operand staging and never receives results.
  localparam logic [2:0] MATRIX_SCRATCH_ID = 3'd7;

  typedef struct packed {
    logic [7:0] rows;
    logic [7:0] cols;
  } matrix_shape_t;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_CHECK,
    WR_WRITE_META,
    WR_STREAM,
    WR_DONE
  } matrix_writer_state_e;

  function automatic logic [31:0] encode_shape_word(input logic [7:0] rows,
                                                    input logic [7:0] cols);
    return {16'h0000, rows, cols};
  endfunction

  function automatic matrix_shape_t decode_shape_word(input logic [31:0] word);
    return matrix_shape_t'(word[15:0]);
  endfunction

  function automatic logic is_valid_result_id(input logic [2:0] id);
    return id != MATRIX_SCRATCH_ID;
  endfunction

endpackage

// File: rtl/matrix_result_writer_if.sv
// Result-write handshake between a matrix operation unit (master) and the
// result writer (slave): one request carrying metadata, then an element stream.
interface matrix_result_writer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  write_ready;
  logic                  write_request;
  logic [2:0]            matrix_id;
  logic [7:0]            actual_rows;
  logic [7:0]            actual_cols;
  logic [7:0]            matrix_name [8];
  logic                  writer_ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  write_done;
  logic                  write_error;

  modport master (
    input  write_ready, writer_ready, write_done, write_error,
    output write_request, matrix_id, actual_rows, actual_cols, matrix_name,
           data_in, data_valid
  );

  modport slave (
    output write_ready, writer_ready, write_done, write_error,
    input  write_request, matrix_id, actual_rows, actual_cols, matrix_name,
           data_in, data_valid
  );
endinterface

// File: rtl/matrix_address_getter.sv
// Maps a matrix slot id to the base address of its storage block.
module matrix_address_getter #(
  parameter int BLOCK_SIZE = 256,
  parameter int ADDR_WIDTH = 12
) (
  input  logic [2:0]            matrix_id,
  output logic [ADDR_WIDTH-1:0] base_addr
);
  assign base_addr = ADDR_WIDTH'(matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);
endmodule

// File: rtl/matrix_result_writer.sv
// Responder for the matrix result-write handshake: validates the destination,
// writes metadata then elements row-major into storage through one write port.
module matrix_result_writer
  import matrix_op_defs_pkg::*;
#(
  parameter int BLOCK_SIZE = MATRIX_BLOCK_SIZE,
  parameter int ADDR_WIDTH = MATRIX_ADDR_WIDTH,
  parameter int DATA_WIDTH = MATRIX_DATA_WIDTH,
  parameter int META_WORDS = MATRIX_METADATA_WORDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  matrix_result_writer_if.slave wr_if,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  matrix_writer_state_e  state_q, state_d;
  logic [2:0]            id_q, id_d;
  logic [7:0]            rows_q, rows_d;
  logic [7:0]            cols_q, cols_d;
  logic [7:0][7:0]       name_q, name_d;
  logic [ADDR_WIDTH-1:0] meta_cnt_q, meta_cnt_d;
  logic [15:0]           elem_cnt_q, elem_cnt_d;
  logic                  discard_q, discard_d;
  logic                  write_error_q, write_error_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [ADDR_WIDTH-1:0] base_addr;
  logic [15:0]           total;
  logic                  reject;

  matrix_address_getter #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_getter (
    .matrix_id (id_q),
    .base_addr (base_addr)
  );

  assign total  = 16'(rows_q) * 16'(cols_q);
  assign reject = !is_valid_result_id(id_q) || (rows_q == 8'd0) || (cols_q == 8'd0)
                  || (total > 16'(MATRIX_DATA_CAPACITY));

  always_comb begin
    // NOTE: every variable gets a default before the case, otherwise paths that
    // do not assign it would infer a latch.
    state_d       = state_q;
    id_d          = id_q;
    rows_d        = rows_q;
    cols_d        = cols_q;
    name_d        = name_q;
    meta_cnt_d    = meta_cnt_q;
    elem_cnt_d    = elem_cnt_q;
    discard_d     = discard_q;
    write_error_d = write_error_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;

    unique case (state_q)
      WR_IDLE: begin
        if (wr_if.write_request) begin
          id_d          = wr_if.matrix_id;
          rows_d        = wr_if.actual_rows;
          cols_d        = wr_if.actual_cols;
          for (int i = 0; i < 8; i++) name_d[i] = wr_if.matrix_name[i];
          write_error_d = 1'b0;
          elem_cnt_d    = '0;
          meta_cnt_d    = '0;
          discard_d     = 1'b0;
          state_d       = WR_CHECK;
        end
      end
      WR_CHECK: begin
        if (reject) begin
          write_error_d = 1'b1;
          // An empty bad job has no beats to drain, so it completes at once.
          if (total == 16'd0) begin
            state_d = WR_DONE;
          end else begin
            discard_d = 1'b1;
            state_d   = WR_STREAM;
          end
        end else begin
          state_d = WR_WRITE_META;
        end
      end
      WR_WRITE_META: begin
        mem_we_d   = 1'b1;
        mem_addr_d = base_addr + meta_cnt_q;
        if (meta_cnt_q == '0)
          mem_wdata_d = DATA_WIDTH'(encode_shape_word(rows_q, cols_q));
        else if (meta_cnt_q == ADDR_WIDTH'(1))
          mem_wdata_d = DATA_WIDTH'(name_q[3:0]);
        else if (meta_cnt_q == ADDR_WIDTH'(2))
          mem_wdata_d = DATA_WIDTH'(name_q[7:4]);
        else
          mem_wdata_d = '0;
        meta_cnt_d = meta_cnt_q + ADDR_WIDTH'(1);
        if (meta_cnt_q == ADDR_WIDTH'(META_WORDS - 1)) state_d = WR_STREAM;
      end
      WR_STREAM: begin
        if (wr_if.data_valid) begin
          if (!discard_q) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = base_addr + ADDR_WIDTH'(META_WORDS) + ADDR_WIDTH'(elem_cnt_q);
            mem_wdata_d = DATA_WIDTH'(wr_if.data_in);
          end
          elem_cnt_d = elem_cnt_q + 16'd1;
          if (elem_cnt_q == total - 16'd1) state_d = WR_DONE;
        end
      end
      WR_DONE: state_d = WR_IDLE;
      default: state_d = WR_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WR_IDLE;
      id_q          <= '0;
      rows_q        <= '0;
      cols_q        <= '0;
      // NOTE: the name bytes are a handful of flops, not a RAM, so resetting
      // them is cheap and keeps the metadata path free of X.
      name_q        <= '0;
      meta_cnt_q    <= '0;
      elem_cnt_q    <= '0;
      discard_q     <= 1'b0;
      write_error_q <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      rows_q        <= rows_d;
      cols_q        <= cols_d;
      name_q        <= name_d;
      meta_cnt_q    <= meta_cnt_d;
      elem_cnt_q    <= elem_cnt_d;
      discard_q     <= discard_d;
      write_error_q <= write_error_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign wr_if.write_ready  = (state_q == WR_IDLE);
  assign wr_if.writer_ready = (state_q == WR_STREAM);
  assign wr_if.write_done   = (state_q == WR_DONE);
  assign wr_if.write_error  = write_error_q;
  assign mem_we             = mem_we_q;
  assign mem_addr           = mem_addr_q;
  assign mem_wdata          = mem_wdata_q;

endmodule

// File: tb/tb_matrix_result_writer.sv
// Directed bench for matrix_result_writer: a storage model captures mem_* writes
// and each step compares against hand-computed addresses, data and timing.
module tb_matrix_result_writer;

  localparam logic [31:0] POISON = 32'hDEAD_BEEF;
  localparam logic [63:0] NAME_MULRES = 64'h0000_5345_524C_554D; // byte 0 = 'M'

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;

  always #5 clk = ~clk;

  matrix_result_writer_if #(.DATA_WIDTH(32)) wr_if ();

  matrix_result_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_if     (wr_if),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  int          tests = 0;
  int          fails = 0;
  int          we_count = 0;
  int          done_count = 0;
  logic [31:0] ram [2048];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 2048; i++) ram[i] = POISON;
  endtask

  task automatic do_request(input logic [2:0] id, input logic [7:0] r,
                            input logic [7:0] c, input logic [63:0] nm);
    wr_if.write_request = 1'b1;
    wr_if.matrix_id     = id;
    wr_if.actual_rows   = r;
    wr_if.actual_cols   = c;
    for (int i = 0; i < 8; i++) wr_if.matrix_name[i] = nm[8*i +: 8];
    @(negedge clk);
    wr_if.write_request = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!wr_if.writer_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Leaves data_valid high after the last beat; the caller drops it.
  task automatic send_beats(input int n, input logic [31:0] first, input int max_gap);
    for (int k = 0; k < n; k++) begin
      int gap;
      int w;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (gap > 0) begin
        wr_if.data_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      wr_if.data_valid = 1'b1;
      wr_if.data_in    = first + 32'(k);
      w = 0;
      while (!wr_if.writer_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("beat_ready", 64'(wr_if.writer_ready), 64'd1);
      @(negedge clk);
    end
  endtask

  task automatic check_mulres_image(input string tag, input logic [31:0] first);
    check({tag, "_meta0"}, 64'(ram[0]), 64'h0000_0203);
    check({tag, "_meta1"}, 64'(ram[1]), 64'h524C_554D);
    check({tag, "_meta2"}, 64'(ram[2]), 64'h0000_5345);
    check({tag, "_meta3"}, 64'(ram[3]), 64'h0);
    for (int k = 0; k < 6; k++) check({tag, "_data"}, 64'(ram[4+k]), 64'(first + 32'(k)));
    check({tag, "_beyond"}, 64'(ram[10]), 64'(POISON));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_write_ready"}, 64'(wr_if.write_ready), 64'd1);
    check({tag, "_writer_ready"}, 64'(wr_if.writer_ready), 64'd0);
    check({tag, "_write_done"}, 64'(wr_if.write_done), 64'd0);
    check({tag, "_write_error"}, 64'(wr_if.write_error), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  // Runs one complete MULRES job on slot 0 and checks its end-of-job behaviour.
  task automatic mulres_job(input string tag, input logic [31:0] first, input int max_gap);
    int n;
    int we0;
    int done0;
    we0   = we_count;
    done0 = done_count;
    clear_ram();
    do_request(3'd0, 8'd2, 8'd3, NAME_MULRES);
    wait_ready(n);
    check({tag, "_ready_latency"}, 64'(n), 64'd5);
    send_beats(6, first, max_gap);
    check({tag, "_done_pulse"}, 64'(wr_if.write_done), 64'd1);
    check({tag, "_last_we"}, 64'(mem_we), 64'd1);
    check({tag, "_last_addr"}, 64'(mem_addr), 64'd9);
    check({tag, "_last_data"}, 64'(mem_wdata), 64'(first + 32'd5));
    check({tag, "_ready_drop"}, 64'(wr_if.writer_ready), 64'd0);
    check({tag, "_error"}, 64'(wr_if.write_error), 64'd0);
    wr_if.data_valid = 1'b0;
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(wr_if.write_done), 64'd0);
    check({tag, "_idle"}, 64'(wr_if.write_ready), 64'd1);
    repeat (2) @(negedge clk);
    check({tag, "_we_count"}, 64'(we_count - we0), 64'd10);
    check({tag, "_done_count"}, 64'(done_count - done0), 64'd1);
    check_mulres_image(tag, first);
  endtask

  initial begin
    int n;
    int we0;
    int done0;

    wr_if.write_request = 1'b0;
    wr_if.matrix_id     = '0;
    wr_if.actual_rows   = '0;
    wr_if.actual_cols   = '0;
    for (int i = 0; i < 8; i++) wr_if.matrix_name[i] = '0;
    wr_if.data_in       = '0;
    wr_if.data_valid    = 1'b0;
    clear_ram();

    fork
      forever begin
        @(negedge clk);
        if (mem_we === 1'b1) begin
          ram[mem_addr] = mem_wdata;
          we_count++;
        end
        if (wr_if.write_done === 1'b1) done_count++;
      end
    join_none

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back stream, then the same job with random valid gaps.
    mulres_job("b2b", 32'd1, 0);
    mulres_job("gaps", 32'd1, 3);

    // Invalid destination: beats drained without writes, error with done.
    we0 = we_count; done0 = done_count;
    do_request(3'd7, 8'd2, 8'd2, NAME_MULRES);
    send_beats(4, 32'h40, 0);
    check("bad_id_done", 64'(wr_if.write_done), 64'd1);
    check("bad_id_error", 64'(wr_if.write_error), 64'd1);
    wr_if.data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bad_id_error_held", 64'(wr_if.write_error), 64'd1);
    check("bad_id_no_we", 64'(we_count - we0), 64'd0);
    check("bad_id_done_count", 64'(done_count - done0), 64'd1);

    // Zero rows: straight to DONE at T+2, never ready for data.
    we0 = we_count;
    do_request(3'd2, 8'd0, 8'd5, 64'h0);
    check("rows0_t1_ready", 64'(wr_if.writer_ready), 64'd0);
    check("rows0_t1_done", 64'(wr_if.write_done), 64'd0);
    @(negedge clk);
    check("rows0_t2_done", 64'(wr_if.write_done), 64'd1);
    check("rows0_t2_error", 64'(wr_if.write_error), 64'd1);
    check("rows0_t2_ready", 64'(wr_if.writer_ready), 64'd0);
    repeat (2) @(negedge clk);
    check("rows0_no_we", 64'(we_count - we0), 64'd0);

    // Just over capacity: 16x16 = 256 > 252 is discarded.
    we0 = we_count; done0 = done_count;
    do_request(3'd1, 8'd16, 8'd16, 64'h0);
    send_beats(256, 32'h0, 0);
    check("over_cap_done", 64'(wr_if.write_done), 64'd1);
    check("over_cap_error", 64'(wr_if.write_error), 64'd1);
    wr_if.data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("over_cap_no_we", 64'(we_count - we0), 64'd0);
    check("over_cap_done_count", 64'(done_count - done0), 64'd1);

    // Exactly at capacity: 14x18 = 252 fills slot 6 (base 1536).
    we0 = we_count;
    clear_ram();
    do_request(3'd6, 8'd14, 8'd18, 64'h0);
    send_beats(252, 32'h1000, 0);
    check("at_cap_done", 64'(wr_if.write_done), 64'd1);
    check("at_cap_error", 64'(wr_if.write_error), 64'd0);
    wr_if.data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("at_cap_we_count", 64'(we_count - we0), 64'd256);
    check("at_cap_meta0", 64'(ram[1536]), 64'h0000_0E12);
    check("at_cap_meta1", 64'(ram[1537]), 64'h0);
    check("at_cap_meta3", 64'(ram[1539]), 64'h0);
    check("at_cap_first", 64'(ram[1540]), 64'h1000);
    check("at_cap_last", 64'(ram[1791]), 64'h1000 + 64'd251);
    check("at_cap_beyond", 64'(ram[1792]), 64'(POISON));

    // Stray request mid-stream and a surplus 7th beat are both ignored.
    we0 = we_count; done0 = done_count;
    clear_ram();
    do_request(3'd0, 8'd2, 8'd3, NAME_MULRES);
    send_beats(3, 32'h21, 0);
    wr_if.data_valid = 1'b0;
    do_request(3'd3, 8'd1, 8'd1, 64'h0);
    send_beats(3, 32'h24, 0);
    check("stray_done", 64'(wr_if.write_done), 64'd1);
    wr_if.data_in = 32'd99;
    repeat (3) @(negedge clk);
    wr_if.data_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_we_count", 64'(we_count - we0), 64'd10);
    check("stray_done_count", 64'(done_count - done0), 64'd1);
    check("stray_idle", 64'(wr_if.write_ready), 64'd1);
    check_mulres_image("stray", 32'h21);
    check("stray_slot3_meta", 64'(ram[768]), 64'(POISON));

    // Reset after beat 3 of 6, then a fresh job completes normally.
    done0 = done_count;
    do_request(3'd0, 8'd2, 8'd3, NAME_MULRES);
    send_beats(3, 32'h31, 0);
    rst_n = 1'b0;
    wr_if.data_valid = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_reset_no_done", 64'(done_count - done0), 64'd0);
    check_reset_outputs("after_reset");
    mulres_job("post_reset", 32'h51, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_result_writer.md
# matrix_result_writer

Responder end of the matrix result-write handshake used by the matrix operation units (multiply, add, transpose, scalar). It accepts one write request carrying destination slot id, shape and 8-byte name, then a stream of elements. It writes the metadata and elements row-major into the matrix storage RAM through a single write port. It signals completion with a one-cycle `write_done`, and flags bad destinations without stalling the initiator.

## Interface
Parameters:
- `BLOCK_SIZE`, default `MATRIX_BLOCK_SIZE`: words per storage slot.
- `ADDR_WIDTH`, default `MATRIX_ADDR_WIDTH`: storage address width.
- `DATA_WIDTH`, default `MATRIX_DATA_WIDTH`: element and metadata word width; must be ≥ 32.
- `META_WORDS`, default `MATRIX_METADATA_WORDS`: metadata words per slot; must be ≥ 3.

Ports:
- `clk`  in  1  system clock. The block uses this single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `write_ready`  out  1  writer idle; high only in IDLE.
- `write_request`  in  1  one-cycle request pulse; sampled only in IDLE.
- `matrix_id`  in  3  destination slot; valid in the `write_request` cycle.
- `actual_rows`, `actual_cols`  in  8 each  result shape; valid in the `write_request` cycle.
- `matrix_name`  in  8×8 array  name bytes [0:7]; valid in the `write_request` cycle.
- `writer_ready`  out  1  high in STREAM; an element is accepted in any cycle with `data_valid && writer_ready`.
- `data_in`  in  DATA_WIDTH  element value.
- `data_valid`  in  1  element present; the initiator holds it until accepted.
- `write_done`  out  1  one-cycle completion pulse.
- `write_error`  out  1  request rejected; valid with `write_done`, held until the next accepted request.
- `mem_we`  out  1  storage write enable.
- `mem_addr`  out  ADDR_WIDTH  storage write address.
- `mem_wdata`  out  DATA_WIDTH  storage write data.

## Operation
- States: IDLE → CHECK → WRITE_META → STREAM → DONE → IDLE.
- IDLE:
  - On `write_request`, latch id, rows, cols and name.
  - Clear `write_error` and the element counter.
  - Go to CHECK.
- CHECK:
  - `total = rows*cols` (16-bit).
  - Reject if any of the following hold:
    - `!is_valid_result_id(id)`
    - rows == 0 or cols == 0
    - `total > MATRIX_DATA_CAPACITY`
  - Reject with total == 0: set `write_error` and go to DONE.
  - Other reject: set `write_error` and go to STREAM in discard mode.
  - Accept: go to WRITE_META.
- WRITE_META: one write per cycle to `base + i`, for i = 0 .. META_WORDS-1:
  - word 0 = `encode_shape_word(rows, cols)`;
  - word 1 = {name[3], name[2], name[1], name[0]}, with name[0] in bits [7:0];
  - word 2 = {name[7], name[6], name[5], name[4]};
  - remaining words = 0;
  - upper bits above 32 are zero.
- STREAM:
  - Each accepted beat k (0-based) writes `data_in` to `base + META_WORDS + k` and increments k.
  - In discard mode there are no `mem_we`; beats are still accepted and counted.
  - When the beat with k == total-1 is accepted, go to DONE.
- DONE: pulse `write_done` for one cycle, then go to IDLE.
- `base` comes from `matrix_address_getter(id)`.

## Timing
- Reset:
  - state = IDLE; `write_ready` = 1.
  - `writer_ready`, `write_done`, `write_error`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata` = 0.
  - Counters = 0.
- Memory outputs are registered: a write decided in cycle t appears on `mem_*` in cycle t+1 for exactly one cycle.
- Request sampled at edge T:
  - CHECK at T+1.
  - Metadata writes visible at T+3 .. T+2+META_WORDS.
  - `writer_ready` first high at T+2+META_WORDS.
- A beat accepted at edge t appears on `mem_*` in cycle t+1. Back-to-back beats are sustained at one per cycle.
- `write_done` is high in the cycle after the last beat is accepted. The last data write and `write_done` are visible in the same cycle.
- `write_request` outside IDLE is ignored.
- `data_valid` outside STREAM is ignored.
- `writer_ready` drops in the cycle after the last beat, so surplus beats are not accepted.
- The element counter is 16-bit and never wraps, because total ≤ MATRIX_DATA_CAPACITY < 2^16.
- Reset mid-operation: return immediately to IDLE with reset values. RAM contents are left partial and no `write_done` is issued.

## Structure
- `matrix_op_defs_pkg` gains:
  - `encode_shape_word(rows, cols)`, which must round-trip exactly with `decode_shape_word`;
  - `is_valid_result_id(id)`;
  - writer state enum `matrix_writer_state_e`.
- The package already holds `MATRIX_METADATA_WORDS`, `MATRIX_DATA_CAPACITY` and the width constants.
- Single sub-module: the existing `matrix_address_getter`, instantiated once on the latched id.

## Test plan
- Id 0, 2×3, name "MULRES", beats 1..6 back-to-back:
  - metadata = shape(2,3), 0x524C554D, 0x00005345, then zeros;
  - data 1..6 at base0+META_WORDS+0..5;
  - `write_done` one cycle after the 6th accept; `write_error` = 0.
- Same request with `data_valid` gaps of 0–3 random cycles → identical RAM image, one write per accepted beat, exactly one `write_done`.
- Invalid id (7), 2×2, 4 beats → zero `mem_we`, all 4 beats accepted, then `write_done` with `write_error` = 1.
- rows = 0 → no `writer_ready`, no `mem_we`; `write_done` with `write_error` = 1 at T+2.
- Second `write_request` during STREAM and a 7th beat offered after a 6-element job → both ignored; RAM unchanged beyond 6 elements.
- `rst_n` low after beat 3 of 6 → outputs return to reset values; `write_done` never pulses; a new request then completes normally.
